logic_unit_seq: RTL



---
 rtl/mini_alu_pkg.sv | 20 ++
 rtl/logic_slice.sv | 29 ++
 rtl/logic_unit_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mini_alu_pkg.sv
// Shared mini-ALU definitions: logic opcodes and the FSM state
// encoding of the slice-serial logic unit.
package mini_alu_pkg;

   localparam logic [2:0] OP_AND   = 3'b000;
   localparam logic [2:0] OP_OR    = 3'b001;
   localparam logic [2:0] OP_XOR   = 3'b010;
   localparam logic [2:0] OP_XNOR  = 3'b011;
   localparam logic [2:0] OP_NAND  = 3'b100;
   localparam logic [2:0] OP_NOR   = 3'b101;
   localparam logic [2:0] OP_NOTA  = 3'b110;
   localparam logic [2:0] OP_PASSA = 3'b111;

   typedef enum logic [1:0] {
      LU_IDLE = 2'd0,
      LU_BUSY = 2'd1,
      LU_DONE = 2'd2
   } lu_state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational bitwise logic on one SLICE-bit chunk.
// Ports: op (3b opcode), a/b (SLICE-bit operands), y (SLICE-bit result).
module logic_slice #(
   parameter int SLICE = 4
) (
   input  logic [2:0]       op,
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   output logic [SLICE-1:0] y
);

   import mini_alu_pkg::*;

   always_comb begin
      y = '0;
      unique case (op)
         OP_AND:   y = a & b;
         OP_OR:    y = a | b;
         OP_XOR:   y = a ^ b;
         OP_XNOR:  y = ~(a ^ b);
         OP_NAND:  y = ~(a & b);
         OP_NOR:   y = ~(a | b);
         OP_NOTA:  y = ~a;
         OP_PASSA: y = a;
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/logic_unit_seq.sv
// Slice-serial bitwise logic unit: latches a, b, op on accept, computes
// SLICE bits per cycle over WIDTH/SLICE cycles, then holds the result
// with zero/all_ones flags until consumed.
// Ports: clk, rst_n (async, active low); in_valid/in_ready, op, a, b
// (input handshake); out_valid/out_ready, result, zero, all_ones.
module logic_unit_seq #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             all_ones
);

   import mini_alu_pkg::*;

   localparam int N  = WIDTH / SLICE;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   lu_state_e        state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             vld_q, vld_d;
   logic             zero_q, zero_d;
   logic             ones_q, ones_d;

   logic [SLICE-1:0] s_a, s_b, s_y;
   logic             last;

   assign s_a  = a_q[int'(idx_q)*SLICE +: SLICE];
   assign s_b  = b_q[int'(idx_q)*SLICE +: SLICE];
   assign last = (idx_q == IW'(N - 1));

   logic_slice #(.SLICE(SLICE)) u_slice (
      .op (op_q),
      .a  (s_a),
      .b  (s_b),
      .y  (s_y)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      vld_d   = vld_q;
      zero_d  = zero_q;
      ones_d  = ones_q;
      unique case (state_q)
         LU_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               idx_d   = '0;
               state_d = LU_BUSY;
            end
         end
         LU_BUSY: begin
            res_d[int'(idx_q)*SLICE +: SLICE] = s_y;
            idx_d = idx_q + 1'b1;
            // flags come from the full result including this last slice
            if (last) begin
               idx_d   = '0;
               zero_d  = (res_d == '0);
               ones_d  = (res_d == '1);
               vld_d   = 1'b1;
               state_d = LU_DONE;
            end
         end
         LU_DONE: begin
            if (out_ready) begin
               vld_d   = 1'b0;
               state_d = LU_IDLE;
            end
         end
         default: state_d = LU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LU_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         vld_q   <= 1'b0;
         zero_q  <= 1'b0;
         ones_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         vld_q   <= vld_d;
         zero_q  <= zero_d;
         ones_q  <= ones_d;
      end
   end

   assign in_ready  = (state_q == LU_IDLE);
   assign out_valid = vld_q;
   assign result    = res_q;
   assign zero      = zero_q;
   assign all_ones  = ones_q;

endmodule
